// File: rtl/gpio_pkg.sv
// Shared GPIO peripheral constants: block base addresses and gpio_in register offsets.
package gpio_pkg;

   localparam logic [31:0] GPIO_OUT_BASE = 32'h0000_0400;
   localparam logic [31:0] GPIO_IN_BASE  = 32'h0000_0410;

   localparam logic [3:0] GPIO_IN_PIN_OFS  = 4'h0;
   localparam logic [3:0] GPIO_IN_RISE_OFS = 4'h4;
   localparam logic [3:0] GPIO_IN_FALL_OFS = 4'h8;
   localparam logic [3:0] GPIO_IN_IE_OFS   = 4'hC;

   // True when addr falls in the 16-byte register window starting at base.
   function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
      return addr[31:4] == base[31:4];
   endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// One-bit pin conditioner: synchroniser chain plus optional debouncer (GPIO_IN_DEBOUNCE_EN).
// stable_nxt_c is the value stable takes on the next edge, used for same-edge edge detection.
module gpio_in_filter #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic stable,
   output logic stable_nxt_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
   end

   assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IN_DEBOUNCE_EN
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_c;

   // A new level is accepted only after it has differed from stable for DEBOUNCE_CYCLES cycles.
   always_comb begin
      cnt_c        = '0;
      stable_nxt_c = stable;
      if (sync != stable) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_nxt_c = sync;
         else                                      cnt_c        = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_c;
   end
`else
   logic [31:0] unused_db_len;
   assign unused_db_len = 32'(DEBOUNCE_CYCLES);

   always_comb stable_nxt_c = sync;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stable <= 1'b0;
      else        stable <= stable_nxt_c;
   end

endmodule

// File: rtl/gpio_in.sv
// Input GPIO: per-pin filter, sticky RISE/FALL W1C flags, IE mask, bus register window and irq.
// Debouncing is enabled by defining GPIO_IN_DEBOUNCE_EN.
module gpio_in
   import gpio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR       = GPIO_IN_BASE,
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pins,
   input  logic             r_en,
   input  logic [31:0]      r_addr,
   output logic [31:0]      r_data,
   input  logic             w_en,
   input  logic [31:0]      w_addr,
   input  logic [31:0]      w_data,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_nxt_c;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;
   logic [WIDTH-1:0] ie_q;
   logic [WIDTH-1:0] rise_clr_c;
   logic [WIDTH-1:0] fall_clr_c;
   logic [WIDTH-1:0] rise_set_c;
   logic [WIDTH-1:0] fall_set_c;
   logic             ie_we_c;
   logic             w_hit_c;
   logic [31:0]      rdata_c;
   logic [31:0]      unused_wdata;

   assign unused_wdata = w_data;

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
`ifdef GPIO_IN_DEBOUNCE_EN
      gpio_in_filter #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_filter (
         .clk          (clk),
         .rst_n        (rst_n),
         .pin          (pins[i]),
         .stable       (stable[i]),
         .stable_nxt_c (stable_nxt_c[i])
      );
`else
      gpio_in_filter #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_filter (
         .clk          (clk),
         .rst_n        (rst_n),
         .pin          (pins[i]),
         .stable       (stable[i]),
         .stable_nxt_c (stable_nxt_c[i])
      );
`endif
   end

   // Edges are taken from the incoming stable value so flags set on the edge stable changes.
   always_comb begin
      rise_set_c = stable_nxt_c & ~stable;
      fall_set_c = ~stable_nxt_c & stable;
      w_hit_c    = w_en && in_window(w_addr, BASE_ADDR);
      rise_clr_c = '0;
      fall_clr_c = '0;
      ie_we_c    = 1'b0;
      if (w_hit_c) begin
         case (w_addr[3:0])
            GPIO_IN_RISE_OFS: rise_clr_c = w_data[WIDTH-1:0];
            GPIO_IN_FALL_OFS: fall_clr_c = w_data[WIDTH-1:0];
            GPIO_IN_IE_OFS:   ie_we_c    = 1'b1;
            default:          ;
         endcase
      end
   end

   always_comb begin
      rdata_c = '0;
      if (r_en && in_window(r_addr, BASE_ADDR)) begin
         case (r_addr[3:0])
            GPIO_IN_PIN_OFS:  rdata_c = 32'(stable);
            GPIO_IN_RISE_OFS: rdata_c = 32'(rise_q);
            GPIO_IN_FALL_OFS: rdata_c = 32'(fall_q);
            GPIO_IN_IE_OFS:   rdata_c = 32'(ie_q);
            default:          rdata_c = '0;
         endcase
      end
   end

   // Set has priority over a same-cycle W1C.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= '0;
         fall_q <= '0;
         ie_q   <= '0;
         r_data <= '0;
         irq    <= 1'b0;
      end else begin
         rise_q <= (rise_q & ~rise_clr_c) | rise_set_c;
         fall_q <= (fall_q & ~fall_clr_c) | fall_set_c;
         if (ie_we_c) ie_q <= w_data[WIDTH-1:0];
         r_data <= rdata_c;
         irq    <= |((rise_q | fall_q) & ie_q);
      end
   end

endmodule

// File: doc/gpio_in.md
# gpio_in

Input-direction GPIO peripheral: samples 8 external pins, synchronises them and (optionally) debounces them, and latches sticky rising/falling edge flags. Software reads it over the core's synchronous read port and clears flags over the write port. It sits on the peripheral bus beside the output GPIO block at base 0x00000410. It raises one level interrupt when any enabled edge flag is set.

## Interface

**Parameters**
- `BASE_ADDR`, default 32'h0000_0410: word-aligned base address of the register window.
- `WIDTH`, default 8: number of input pins, 1..32.
- `SYNC_STAGES`, default 2: flip-flop synchroniser depth, ≥2.
- `DEBOUNCE_CYCLES`, default 16: cycles an input must hold a new value before it is accepted, ≥1.

**Ports**
- `clk`, input, 1: system clock; all logic on posedge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `pins`, input, WIDTH: raw asynchronous pin levels.
- `r_en`, input, 1: read enable.
- `r_addr`, input, 32: byte read address.
- `r_data`, output, 32: registered read data.
- `w_en`, input, 1: write enable.
- `w_addr`, input, 32: byte write address.
- `w_data`, input, 32: write data.
- `irq`, output, 1: registered interrupt, level-high.

## Operation

Register map (offsets from `BASE_ADDR`; bits ≥ WIDTH always read 0):
- 0x0 PIN, RO: accepted (stable) pin levels.
- 0x4 RISE, R/W1C: sticky flags, bit i set on a 0→1 transition of stable bit i.
- 0x8 FALL, R/W1C: sticky flags, bit i set on a 1→0 transition of stable bit i.
- 0xC IE, R/W: per-pin interrupt enable; a pin's bit enables both its RISE and FALL flags.

Pin path, per bit:
- The synchroniser chain feeds `sync[i]`.
- The debouncer then updates `stable[i]` as defined under Configuration.
- Edge detection compares `stable` with its previous-cycle value.

Flag update rule, each cycle:
- `flag <= (flag & ~clr) | edge`.
- When an edge and a W1C of the same bit occur in the same cycle, the set wins.

Write handling:
- Addresses in the window other than 0x4, 0x8 and 0xC are ignored.
- Out-of-window writes are ignored.

Read handling:
- `r_data` ≤ selected register when `r_en` is high and the address is in the window.
- Otherwise `r_data` ≤ 0.
- A read and a write to the same register in the same cycle return the pre-write value.

Interrupt: `irq <= |((RISE | FALL) & IE)`.

Reset values: `r_data`, `irq`, sync chain, stable, previous-stable, counters, RISE, FALL and IE are all 0. No edge is flagged for pins that are already high when reset is released until they are accepted. Accepting that high produces one RISE flag.

## Timing

- Read latency: exactly 1 cycle, no stall. `r_data` is valid on the edge after the `r_en` cycle and holds until the next edge.
- Write effect: visible to a read issued in the following cycle.
- Pin to PIN latency:
  - Debounce on: SYNC_STAGES + DEBOUNCE_CYCLES edges after the first sampling edge, for an input held steady.
  - Debounce off: SYNC_STAGES + 1 edges.
- Edge to flag: the flag is set on the same edge that `stable` changes.
- Flag to irq: `irq` rises 1 cycle after the flag.
- W1C to irq: `irq` drops 1 cycle after the clear, provided no other enabled flag remains set.
- Reset asserted mid-operation: every state returns immediately (asynchronously) to its reset value, and any pending counts are discarded.

## Configuration

Macro: `GPIO_IN_DEBOUNCE_EN`.

- **Defined:**
  - Each pin has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - While `sync` ≠ `stable`, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES−1 with `sync` still ≠ `stable`, `stable` ≤ `sync` and the counter ≤ 0.
  - When `sync` = `stable`, the counter ≤ 0. Glitches shorter than DEBOUNCE_CYCLES are therefore rejected.
- **Undefined:**
  - `stable` ≤ `sync` every cycle.
  - No counters are instantiated, and DEBOUNCE_CYCLES is unused.

## Structure

- Shared package `gpio_pkg` holds:
  - offset constants GPIO_IN_PIN_OFS, GPIO_IN_RISE_OFS, GPIO_IN_FALL_OFS, GPIO_IN_IE_OFS;
  - base-address constants for the GPIO blocks.
- Sub-module `gpio_in_filter` covers one bit: synchroniser plus optional debouncer, output `stable`. It is instantiated WIDTH times with a generate loop.
- The top level holds edge detection, the flag registers, address decode and `irq`.

## Test plan

- **Reset:** hold `rst_n`=0 with `pins`=8'hFF. Required: `r_data`=0 and `irq`=0. After release and the Timing pin-to-PIN latency, PIN reads 0xFF and RISE reads 0xFF.
- **Debounce (macro defined, DEBOUNCE_CYCLES=16):** drive a 10-cycle pulse on pin 3. Required: PIN stays 0x00 and RISE stays 0. A steady high on pin 3 gives PIN=0x08 exactly 18 edges after sampling.
- **Edge flags and irq:** set IE=0x01, then toggle pin 0 as 0→1→0. Required: RISE=0x01, FALL=0x01, `irq`=1. Write 0x01 to RISE; `irq` stays 1 because FALL is still set. Write 0x01 to FALL; `irq` falls 1 cycle later.
- **Set beats clear:** issue a W1C to RISE bit 2 in the same cycle that `stable[2]` rises. Required: RISE bit 2 reads 1 afterwards.
- **Read decode:** read 0x410 with PIN=0xA5 → 0x000000A5 one cycle later. Read 0x420 → 0. A cycle with `r_en`=0 → 0. Write 0xFFFFFFFF to IE → IE reads 0x000000FF.
- **Macro undefined:** a 1-cycle-wide pulse on pin 7 that lands on a sampling edge appears in PIN for 1 cycle, and sets both RISE bit 7 and FALL bit 7.
